// File: rtl/axi_read_slave.sv
// AXI read-channel responder: one outstanding burst, FIXED/INCR/WRAP beats
// served from an internal word memory with a backdoor write port.
module axi_read_slave #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int MemDepth = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata,
  input  logic [tagbits-1:0]          ARID,
  input  logic [BusWidth-1:0]         ARADDR,
  input  logic [3:0]                  ARLEN,
  input  logic [1:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic [1:0]                  ARLOCK,
  input  logic [3:0]                  ARCACHE,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [tagbits-1:0]          RID,
  output logic [BusWidth-1:0]         RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY
);

  localparam int AW = $clog2(MemDepth);
  localparam logic [BusWidth-1:0] DEPTH = BusWidth'(MemDepth);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [BusWidth-1:0] mem [MemDepth];
  logic [BusWidth-1:0] addr_q;
  logic [3:0]          len_q;
  logic [1:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [3:0]          cnt;

  logic [BusWidth-1:0] sz;
  logic [BusWidth-1:0] bound;
  logic [BusWidth-1:0] wrap_addr;
  logic [BusWidth-1:0] nxt_addr;
  logic [BusWidth-1:0] ld_addr;
  logic [BusWidth-1:0] widx;
  logic [BusWidth-1:0] ld_data;
  logic [1:0]          ld_resp;
  logic                req_err;
  logic                ld_err;
  logic                ld_bad;
  logic                unused_sideband;

  assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

  // Backdoor port is live in every state, reset included.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    sz        = BusWidth'(1) << size_q;
    bound     = (BusWidth'(len_q) + BusWidth'(1)) << size_q;
    wrap_addr = (addr_q & ~(bound - BusWidth'(1)))
              | ((addr_q + sz) & (bound - BusWidth'(1)));
    nxt_addr  = addr_q;
    unique case (burst_q)
      2'b01:   nxt_addr = addr_q + sz;
      2'b10:   nxt_addr = wrap_addr;
      default: nxt_addr = addr_q;
    endcase
    req_err = (ARBURST == 2'b11) || (ARSIZE == 2'b11)
           || (ARLEN > 4'd3)
           || ((ARBURST == 2'b10) && (ARLEN != 4'd1) && (ARLEN != 4'd3));
    // Beat 0 comes straight from the request, later beats from the latched burst.
    ld_addr = (state == IDLE) ? ARADDR : nxt_addr;
    ld_err  = (state == IDLE) ? req_err : err_q;
    widx    = ld_addr >> 2;
    ld_bad  = ld_err || (widx >= DEPTH);
    ld_data = ld_bad ? '0 : mem[widx[AW-1:0]];
    ld_resp = ld_bad ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
      cnt     <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ARVALID && ARREADY) begin
            addr_q  <= ARADDR;
            len_q   <= ARLEN;
            size_q  <= ARSIZE;
            burst_q <= ARBURST;
            err_q   <= req_err;
            cnt     <= '0;
            RID     <= ARID;
            RDATA   <= ld_data;
            RRESP   <= ld_resp;
            RLAST   <= (ARLEN == 4'd0);
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            state   <= SEND;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        SEND: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              state   <= IDLE;
            end else begin
              addr_q <= nxt_addr;
              cnt    <= cnt + 4'd1;
              RDATA  <= ld_data;
              RRESP  <= ld_resp;
              RLAST  <= ((cnt + 4'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: burst table driven through a beat scoreboard,
// plus reset-mid-burst and backdoor-collision sequences.
module tb_axi_read_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [0:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  always #5 ACLK = ~ACLK;

  axi_read_slave #(.BusWidth(32), .tagbits(1), .MemDepth(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [1:0]       size;
    logic [1:0]       burst;
    logic             id;
    logic [7:0]       pat;
    logic [5:0][31:0] data;
    logic [5:0][1:0]  resp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
  } beat_t;

  beat_t exp_q[$];
  vec_t  tbl[12];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int l,
                              input int s, input logic [1:0] b,
                              input logic id, input logic [7:0] p,
                              input logic [5:0][31:0] d,
                              input logic [11:0] r);
    vec_t v;
    v.addr = a; v.len = 4'(l); v.size = 2'(s); v.burst = b;
    v.id = id; v.pat = p; v.data = d; v.resp = r;
    return v;
  endfunction

  task automatic run_burst(input vec_t v, input bit collide);
    int n, cyc, got, w;
    bit stall;
    logic [35:0] sv, cur;
    beat_t b;
    n = int'(v.len) + 1;
    w = 0;
    while (ARREADY !== 1'b1 && w < 20) begin
      @(negedge ACLK);
      w++;
    end
    chk("arready_wait", 64'(ARREADY), 64'd1);
    ARVALID = 1'b1; ARID = v.id; ARADDR = v.addr; ARLEN = v.len;
    ARSIZE = v.size; ARBURST = v.burst;
    if (collide) begin
      mem_we = 1'b1; mem_waddr = 4'd1; mem_wdata = 32'h55;
    end
    for (int i = 0; i < n; i++) begin
      b.data = v.data[i]; b.resp = v.resp[i];
      b.last = (i == n - 1); b.id = v.id;
      exp_q.push_back(b);
    end
    @(negedge ACLK);
    ARVALID = 1'b0; mem_we = 1'b0;
    ARADDR = $urandom; ARLEN = 4'($urandom); ARBURST = 2'($urandom);
    chk("r_latency", 64'({RVALID, ARREADY}), 64'b10);
    cyc = 0; got = 0; stall = 0; sv = '0;
    while (got < n && cyc < 64) begin
      RREADY = v.pat[cyc % 8];
      cur = {RDATA, RRESP, RLAST, RID};
      if (stall) chk("stall_hold", 64'(cur), 64'(sv));
      stall = 0;
      chk("rvalid_busy", 64'({RVALID, ARREADY}), 64'b10);
      if (RVALID && RREADY) begin
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("rdata", 64'(RDATA), 64'(b.data));
          chk("rresp", 64'(RRESP), 64'(b.resp));
          chk("rlast", 64'(RLAST), 64'(b.last));
          chk("rid", 64'(RID), 64'(b.id));
        end
        got++;
      end else if (RVALID) begin
        sv = cur;
        stall = 1;
      end
      @(negedge ACLK);
      cyc++;
    end
    RREADY = 1'b0;
    chk("beat_count", 64'(got), 64'(n));
    exp_q.delete();
    chk("idle_after", 64'({RVALID, ARREADY}), 64'b01);
  endtask

  vec_t c;

  initial begin
    ARESET = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARLOCK = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    tbl[0]  = mk(32'h4, 3, 2, 2'b01, 1'b1, 8'hFF,
                 {32'h0, 32'h0, 32'hA4, 32'hA3, 32'hA2, 32'hA1}, 12'h000);
    tbl[1]  = mk(32'h8, 3, 2, 2'b10, 1'b0, 8'hFF,
                 {32'h0, 32'h0, 32'hA1, 32'hA0, 32'hA3, 32'hA2}, 12'h000);
    tbl[2]  = mk(32'hC, 2, 2, 2'b00, 1'b1, 8'hFF,
                 {32'h0, 32'h0, 32'h0, 32'hA3, 32'hA3, 32'hA3}, 12'h000);
    tbl[3]  = mk(32'h0, 3, 2, 2'b01, 1'b0, 8'hB2,
                 {32'h0, 32'h0, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 12'h000);
    tbl[4]  = mk(32'h3C, 1, 2, 2'b01, 1'b1, 8'hFF,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hAF},
                 12'b00_00_00_00_10_00);
    tbl[5]  = mk(32'h0, 1, 2, 2'b11, 1'b0, 8'hFF, '0,
                 12'b00_00_00_00_10_10);
    tbl[6]  = mk(32'h0, 5, 2, 2'b01, 1'b1, 8'hFF, '0, 12'hAAA);
    tbl[7]  = mk(32'h4, 1, 2, 2'b10, 1'b0, 8'hFF,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1}, 12'h000);
    tbl[8]  = mk(32'h5, 3, 0, 2'b01, 1'b1, 8'hFF,
                 {32'h0, 32'h0, 32'hA2, 32'hA1, 32'hA1, 32'hA1}, 12'h000);
    tbl[9]  = mk(32'h0, 2, 2, 2'b10, 1'b0, 8'hFF, '0,
                 12'b00_00_00_10_10_10);
    tbl[10] = mk(32'h0, 0, 3, 2'b01, 1'b1, 8'hFF, '0, 12'h002);
    tbl[11] = mk(32'h6, 3, 1, 2'b10, 1'b0, 8'h6D,
                 {32'h0, 32'h0, 32'hA1, 32'hA0, 32'hA0, 32'hA1}, 12'h000);

    for (int i = 0; i < 16; i++) begin
      @(negedge ACLK);
      mem_we = 1'b1; mem_waddr = 4'(i); mem_wdata = 32'hA0 + 32'(i);
    end
    @(negedge ACLK);
    mem_we = 1'b0;
    chk("reset_out", 64'({ARREADY, RVALID, RLAST, RID, RRESP, RDATA}), 64'd0);
    ARESET = 1'b0;
    #1 chk("arready_pre_edge", 64'(ARREADY), 64'd0);
    @(negedge ACLK);
    chk("arready_post_rst", 64'({ARREADY, RVALID}), 64'b10);

    for (int i = 0; i < 12; i++) run_burst(tbl[i], 1'b0);

    c = mk(32'h4, 0, 2, 2'b01, 1'b1, 8'hFF,
           {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA1}, 12'h000);
    run_burst(c, 1'b1);
    c.data[0] = 32'h55;
    run_burst(c, 1'b0);

    @(negedge ACLK);
    mem_we = 1'b1; mem_waddr = 4'd1; mem_wdata = 32'hA1;
    @(negedge ACLK);
    mem_we = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h0; ARLEN = 4'd3; ARSIZE = 2'd2;
    ARBURST = 2'b01; ARID = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    chk("rst_b0", 64'(RDATA), 64'hA0);
    @(negedge ACLK);
    chk("rst_b1", 64'(RDATA), 64'hA1);
    @(negedge ACLK);
    chk("rst_b2", 64'({RVALID, RDATA}), {31'd0, 1'b1, 32'hA2});
    ARESET = 1'b1;
    #1 chk("rst_async", 64'({RVALID, RLAST, ARREADY}), 64'd0);
    @(negedge ACLK);
    chk("rst_hold", 64'({RVALID, RDATA}), 64'd0);
    ARESET = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    chk("rst_release", 64'({ARREADY, RVALID}), 64'b10);
    run_burst(tbl[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
